// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (IF, LSU) and the backend.
// slave  : arbiter side
// master : requester/backend model side
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_done;
  logic [31:0] if_data;

  logic        ls_req;
  logic        ls_we;
  logic [1:0]  ls_len;
  logic        ls_sext;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_done;
  logic [31:0] ls_rdata;

  logic        be_valid;
  logic        be_we;
  logic [1:0]  be_len;
  logic [31:0] be_addr;
  logic [31:0] be_wdata;
  logic        be_ready;
  logic        be_done;
  logic [31:0] be_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_done, if_data,
    input  ls_req, ls_we, ls_len, ls_sext, ls_addr, ls_wdata,
    output ls_gnt, ls_done, ls_rdata,
    output be_valid, be_we, be_len, be_addr, be_wdata,
    input  be_ready, be_done, be_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_done, if_data,
    output ls_req, ls_we, ls_len, ls_sext, ls_addr, ls_wdata,
    input  ls_gnt, ls_done, ls_rdata,
    input  be_valid, be_we, be_len, be_addr, be_wdata,
    output be_ready, be_done, be_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing the byte-serialising memory controller between instruction
// fetch (word reads) and the load/store unit. LSU has priority; a starvation
// counter forces IF through after STARVE_MAX LSU grants. IF fetches can be
// flushed; the backend transaction still completes but its result is dropped.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  input  logic          flush_in,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  logic [1:0]    state;
  logic          owner;
  logic          kill;
  logic [CW-1:0] starve_cnt;
  logic [1:0]    len_q;
  logic          sext_q;

  logic          if_gnt_q, if_done_q, ls_gnt_q, ls_done_q;
  logic [31:0]   if_data_q, ls_rdata_q;
  logic          be_valid_q, be_we_q;
  logic [1:0]    be_len_q;
  logic [31:0]   be_addr_q, be_wdata_q;

  logic          pick_if, pick_ls;
  logic [1:0]    ls_len_norm;
  logic [31:0]   ld_ext;

  assign bus.if_gnt   = if_gnt_q;
  assign bus.if_done  = if_done_q;
  assign bus.if_data  = if_data_q;
  assign bus.ls_gnt   = ls_gnt_q;
  assign bus.ls_done  = ls_done_q;
  assign bus.ls_rdata = ls_rdata_q;
  assign bus.be_valid = be_valid_q;
  assign bus.be_we    = be_we_q;
  assign bus.be_len   = be_len_q;
  assign bus.be_addr  = be_addr_q;
  assign bus.be_wdata = be_wdata_q;

  // Requester selection in IDLE: LSU first unless IF has starved long enough
  always_comb begin
    pick_if = bus.if_req & ~flush_in & (~bus.ls_req | (starve_cnt == STARVE_LIM));
    pick_ls = ~pick_if & bus.ls_req;
    ls_len_norm = (bus.ls_len == 2'b11) ? 2'b10 : bus.ls_len;
  end

  // Load result extension using the length/sign latched at grant
  always_comb begin
    ld_ext = bus.be_rdata;
    case (len_q)
      2'b00:   ld_ext = {{24{sext_q & bus.be_rdata[7]}},  bus.be_rdata[7:0]};
      2'b01:   ld_ext = {{16{sext_q & bus.be_rdata[15]}}, bus.be_rdata[15:0]};
      default: ld_ext = bus.be_rdata;
    endcase
  end

  // Transaction FSM, grant/done pulses, starvation counter and flush kill
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= S_IDLE;
      owner      <= OWN_IF;
      kill       <= 1'b0;
      starve_cnt <= '0;
      len_q      <= '0;
      sext_q     <= 1'b0;
      if_gnt_q   <= 1'b0;
      if_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_gnt_q   <= 1'b0;
      ls_done_q  <= 1'b0;
      ls_rdata_q <= '0;
      be_valid_q <= 1'b0;
      be_we_q    <= 1'b0;
      be_len_q   <= '0;
      be_addr_q  <= '0;
      be_wdata_q <= '0;
    end else if (rdy_in) begin
      if_gnt_q  <= 1'b0;
      if_done_q <= 1'b0;
      ls_gnt_q  <= 1'b0;
      ls_done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_if) begin
            if_gnt_q   <= 1'b1;
            be_valid_q <= 1'b1;
            be_we_q    <= 1'b0;
            be_len_q   <= 2'b10;
            be_addr_q  <= bus.if_addr;
            be_wdata_q <= '0;
            len_q      <= 2'b10;
            sext_q     <= 1'b0;
            owner      <= OWN_IF;
            kill       <= 1'b0;
            starve_cnt <= '0;
            state      <= S_ISSUE;
          end else if (pick_ls) begin
            ls_gnt_q   <= 1'b1;
            be_valid_q <= 1'b1;
            be_we_q    <= bus.ls_we;
            be_len_q   <= ls_len_norm;
            be_addr_q  <= bus.ls_addr;
            be_wdata_q <= bus.ls_we ? bus.ls_wdata : '0;
            len_q      <= ls_len_norm;
            sext_q     <= bus.ls_sext;
            owner      <= OWN_LS;
            kill       <= 1'b0;
            if (bus.if_req && starve_cnt != STARVE_LIM)
              starve_cnt <= starve_cnt + 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (flush_in && owner == OWN_IF)
            kill <= 1'b1;
          if (bus.be_ready) begin
            be_valid_q <= 1'b0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.be_done) begin
            state <= S_IDLE;
            kill  <= 1'b0;
            if (owner == OWN_IF) begin
              // flush arriving together with be_done also drops the fetch
              if (!kill && !flush_in) begin
                if_done_q <= 1'b1;
                if_data_q <= bus.be_rdata;
              end
            end else begin
              ls_done_q  <= 1'b1;
              ls_rdata_q <= be_we_q ? '0 : ld_ext;
            end
          end else if (flush_in && owner == OWN_IF) begin
            kill <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: priority, starvation, flush, extension,
// ready stall and reset behaviour.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  logic rdy;
  logic flush;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] last_if;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .rdy_in   (rdy),
    .flush_in (flush),
    .bus      (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    rdy = 1'b1;
    flush = 1'b0;
    bus.if_req = 1'b0;  bus.if_addr = '0;
    bus.ls_req = 1'b0;  bus.ls_we = 1'b0; bus.ls_len = 2'b00; bus.ls_sext = 1'b0;
    bus.ls_addr = '0;   bus.ls_wdata = '0;
    bus.be_ready = 1'b0; bus.be_done = 1'b0; bus.be_rdata = '0;

    #2;
    chk("rst_if_gnt", {31'b0, bus.if_gnt}, 32'd0);
    chk("rst_be_valid", {31'b0, bus.be_valid}, 32'd0);
    chk("rst_if_data", bus.if_data, 32'd0);
    chk("rst_ls_rdata", bus.ls_rdata, 32'd0);
    step();
    rst = 1'b1;
    step();

    // Lone IF fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    step();
    bus.if_req = 1'b0;
    chk("t2_if_gnt", {31'b0, bus.if_gnt}, 32'd1);
    chk("t2_be_valid", {31'b0, bus.be_valid}, 32'd1);
    chk("t2_be_len", {30'b0, bus.be_len}, 32'd2);
    chk("t2_be_addr", bus.be_addr, 32'h100);
    chk("t2_be_we", {31'b0, bus.be_we}, 32'd0);
    bus.be_ready = 1'b1;
    step();
    bus.be_ready = 1'b0;
    chk("t2_gnt_pulse", {31'b0, bus.if_gnt}, 32'd0);
    chk("t2_valid_drop", {31'b0, bus.be_valid}, 32'd0);
    step(); step(); step();
    chk("t2_no_early_done", {31'b0, bus.if_done}, 32'd0);
    bus.be_done = 1'b1; bus.be_rdata = 32'hDEADBEEF;
    step();
    bus.be_done = 1'b0;
    chk("t2_if_done", {31'b0, bus.if_done}, 32'd1);
    chk("t2_if_data", bus.if_data, 32'hDEADBEEF);
    step();
    chk("t2_done_pulse", {31'b0, bus.if_done}, 32'd0);
    chk("t2_data_hold", bus.if_data, 32'hDEADBEEF);

    // Simultaneous requests: LSU byte load with sign extension first
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_len = 2'b00; bus.ls_sext = 1'b1;
    bus.ls_addr = 32'h40;
    step();
    bus.ls_req = 1'b0;
    chk("t3_ls_gnt", {31'b0, bus.ls_gnt}, 32'd1);
    chk("t3_if_not_gnt", {31'b0, bus.if_gnt}, 32'd0);
    chk("t3_be_addr", bus.be_addr, 32'h40);
    chk("t3_be_len", {30'b0, bus.be_len}, 32'd0);
    bus.be_ready = 1'b1;
    step();
    bus.be_ready = 1'b0;
    bus.be_done = 1'b1; bus.be_rdata = 32'h000000F0;
    step();
    bus.be_done = 1'b0;
    chk("t3_ls_done", {31'b0, bus.ls_done}, 32'd1);
    chk("t3_ls_rdata", bus.ls_rdata, 32'hFFFFFFF0);
    chk("t3_if_bubble", {31'b0, bus.if_gnt}, 32'd0);
    step();
    bus.if_req = 1'b0;
    chk("t3_if_gnt", {31'b0, bus.if_gnt}, 32'd1);
    chk("t3_if_addr", bus.be_addr, 32'h200);
    bus.be_ready = 1'b1;
    step();
    bus.be_ready = 1'b0;
    bus.be_done = 1'b1; bus.be_rdata = 32'h11111111;
    step();
    bus.be_done = 1'b0;
    chk("t3_if_data", bus.if_data, 32'h11111111);

    // Starvation: four LSU grants then IF
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_len = 2'b10; bus.ls_sext = 1'b0;
    bus.ls_addr = 32'h80;
    bus.if_req = 1'b1; bus.if_addr = 32'h400;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_if_gnt", {31'b0, bus.if_gnt}, (i == 4) ? 32'd1 : 32'd0);
      chk("t4_ls_gnt", {31'b0, bus.ls_gnt}, (i == 4) ? 32'd0 : 32'd1);
      if (i == 3) chk("t4_starve_full", 32'(dut.starve_cnt), 32'd4);
      if (i == 4) begin
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        chk("t4_starve_clr", 32'(dut.starve_cnt), 32'd0);
      end
      bus.be_ready = 1'b1;
      step();
      bus.be_ready = 1'b0;
      bus.be_done = 1'b1;
      bus.be_rdata = (i == 4) ? 32'h55AA55AA : 32'hCAFE0000;
      step();
      bus.be_done = 1'b0;
      if (i < 4) chk("t4_ls_rdata", bus.ls_rdata, 32'hCAFE0000);
      else       chk("t4_if_data", bus.if_data, 32'h55AA55AA);
    end
    last_if = 32'h55AA55AA;

    // Flush during WAIT drops the fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    step();
    bus.if_req = 1'b0;
    chk("t5_if_gnt", {31'b0, bus.if_gnt}, 32'd1);
    bus.be_ready = 1'b1;
    step();
    bus.be_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    bus.be_done = 1'b1; bus.be_rdata = 32'h77777777;
    step();
    bus.be_done = 1'b0;
    chk("t5_no_done", {31'b0, bus.if_done}, 32'd0);
    chk("t5_data_hold", bus.if_data, last_if);

    // Half store with rdy stall in ISSUE (also proves FSM returned to IDLE)
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_len = 2'b01;
    bus.ls_addr = 32'h20; bus.ls_wdata = 32'h1234ABCD;
    step();
    bus.ls_req = 1'b0;
    chk("t6_ls_gnt", {31'b0, bus.ls_gnt}, 32'd1);
    chk("t6_be_we", {31'b0, bus.be_we}, 32'd1);
    rdy = 1'b0;
    bus.be_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_stall_valid", {31'b0, bus.be_valid}, 32'd1);
      chk("t6_stall_wdata", bus.be_wdata, 32'h1234ABCD);
      chk("t6_stall_len", {30'b0, bus.be_len}, 32'd1);
      chk("t6_stall_addr", bus.be_addr, 32'h20);
    end
    rdy = 1'b1;
    step();
    bus.be_ready = 1'b0;
    chk("t6_valid_drop", {31'b0, bus.be_valid}, 32'd0);
    chk("t6_gnt_pulse", {31'b0, bus.ls_gnt}, 32'd0);
    bus.be_done = 1'b1; bus.be_rdata = 32'hFFFFFFFF;
    step();
    bus.be_done = 1'b0;
    chk("t6_ls_done", {31'b0, bus.ls_done}, 32'd1);
    chk("t6_ls_rdata", bus.ls_rdata, 32'd0);
    step();

    // Half loads (sign/zero) and length 11 treated as word
    for (int i = 0; i < 3; i++) begin
      bus.ls_req = 1'b1; bus.ls_we = 1'b0;
      bus.ls_len = (i == 2) ? 2'b11 : 2'b01;
      bus.ls_sext = (i != 1);
      bus.ls_addr = 32'h60;
      step();
      bus.ls_req = 1'b0;
      chk("t7_be_len", {30'b0, bus.be_len}, (i == 2) ? 32'd2 : 32'd1);
      bus.be_ready = 1'b1;
      step();
      bus.be_ready = 1'b0;
      bus.be_done = 1'b1;
      bus.be_rdata = (i == 2) ? 32'h80000001 : 32'h12348001;
      step();
      bus.be_done = 1'b0;
      chk("t7_ls_rdata", bus.ls_rdata,
          (i == 0) ? 32'hFFFF8001 : (i == 1) ? 32'h00008001 : 32'h80000001);
    end

    // Flush blocks IF grant in IDLE; flush coincident with be_done drops fetch
    bus.if_req = 1'b1; bus.if_addr = 32'h500;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t8_flush_no_gnt", {31'b0, bus.if_gnt}, 32'd0);
    step();
    bus.if_req = 1'b0;
    chk("t8_if_gnt", {31'b0, bus.if_gnt}, 32'd1);
    bus.be_ready = 1'b1;
    step();
    bus.be_ready = 1'b0;
    bus.be_done = 1'b1; bus.be_rdata = 32'h99999999;
    flush = 1'b1;
    step();
    bus.be_done = 1'b0;
    flush = 1'b0;
    chk("t8_no_done", {31'b0, bus.if_done}, 32'd0);
    chk("t8_data_hold", bus.if_data, last_if);

    // Reset in the middle of WAIT
    bus.if_req = 1'b1; bus.if_addr = 32'h600;
    step();
    bus.if_req = 1'b0;
    bus.be_ready = 1'b1;
    step();
    bus.be_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("t1_if_data", bus.if_data, 32'd0);
    chk("t1_ls_rdata", bus.ls_rdata, 32'd0);
    chk("t1_be_addr", bus.be_addr, 32'd0);
    chk("t1_be_valid", {31'b0, bus.be_valid}, 32'd0);
    step();
    rst = 1'b1;
    bus.be_done = 1'b1; bus.be_rdata = 32'hAAAAAAAA;
    step();
    bus.be_done = 1'b0;
    chk("t1_ignored_done", {31'b0, bus.if_done}, 32'd0);
    chk("t1_if_data_zero", bus.if_data, 32'd0);
    chk("t1_no_gnt", {31'b0, bus.if_gnt}, 32'd0);
    chk("t1_idle", 32'(dut.state), 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
